// File: rtl/systolic_result_collector_pkg.sv
// Shared types and sizing helpers for the systolic result collector.
// Optional build macro used by this slice: COLLECT_TRANSPOSE_EN (column-major drain order).
package systolic_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DRAIN   = 2'd2
    } state_t;

    localparam int DATAWIDTH_DEFAULT = 16;
    localparam int ACC_W             = 2 * DATAWIDTH_DEFAULT;

    // Index width that never collapses to zero bits, so N_SIZE = 1 still has a port.
    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int acc_w(input int dw);
        return 2 * dw;
    endfunction

endpackage

// File: rtl/systolic_result_collector_index_gen.sv
// Row/column index pair for the drain stream: wrap, advance, last detect and ordering.
// With COLLECT_TRANSPOSE_EN defined the row index moves fastest (column-major order).
module collector_index_gen
    import systolic_pkg::*;
#(
    parameter int N_SIZE = 5,
    parameter int IW     = idx_w(N_SIZE)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          advance,
    output logic [IW-1:0] row,
    output logic [IW-1:0] col,
    output logic [IW-1:0] row_next,
    output logic [IW-1:0] col_next,
    output logic          last
);

    localparam logic [IW-1:0] LAST_IDX = IW'(N_SIZE - 1);

    logic [IW-1:0] row_reg;
    logic [IW-1:0] col_reg;

    always_comb begin
        row_next = row_reg;
        col_next = col_reg;
        if (advance) begin
`ifdef COLLECT_TRANSPOSE_EN
            if (row_reg == LAST_IDX) begin
                row_next = '0;
                col_next = (col_reg == LAST_IDX) ? '0 : col_reg + 1'b1;
            end else begin
                row_next = row_reg + 1'b1;
            end
`else
            if (col_reg == LAST_IDX) begin
                col_next = '0;
                row_next = (row_reg == LAST_IDX) ? '0 : row_reg + 1'b1;
            end else begin
                col_next = col_reg + 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_reg <= '0;
            col_reg <= '0;
        end else begin
            row_reg <= row_next;
            col_reg <= col_next;
        end
    end

    assign row  = row_reg;
    assign col  = col_reg;
    assign last = (row_reg == LAST_IDX) && (col_reg == LAST_IDX);

endmodule

// File: rtl/systolic_result_collector.sv
// Captures N_SIZE result rows from systolic_array, then streams the matrix out element by element.
// Build macro COLLECT_TRANSPOSE_EN switches the drain order to column-major.
module systolic_result_collector
    import systolic_pkg::*;
#(
    parameter int DATAWIDTH = 16,
    parameter int N_SIZE    = 5
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          valid_in,
    input  logic [N_SIZE*2*DATAWIDTH-1:0] row_in,
    output logic                          in_ready,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [2*DATAWIDTH-1:0]        out_data,
    output logic [idx_w(N_SIZE)-1:0]      out_row,
    output logic [idx_w(N_SIZE)-1:0]      out_col,
    output logic                          out_last,
    output logic                          overrun
);

    localparam int              EW       = acc_w(DATAWIDTH);
    localparam int              IW       = idx_w(N_SIZE);
    localparam logic [IW-1:0]   LAST_IDX = IW'(N_SIZE - 1);

    state_t          state_reg;
    state_t          state_next;
    logic [IW-1:0]   row_cnt_reg;
    logic [IW-1:0]   row_cnt_next;
    logic            overrun_reg;
    logic [EW-1:0]   out_data_reg;
    logic [EW-1:0]   out_data_next;

    logic [EW-1:0]   row_cols [N_SIZE];
    logic [EW-1:0]   buf_mem  [N_SIZE][N_SIZE];

    logic [IW-1:0]   row_next;
    logic [IW-1:0]   col_next;
    logic            advance;
    logic            final_hs;
    logic            wr_en;
    logic [IW-1:0]   wr_row;

    // Column 0 sits in the most significant slice of row_in.
    generate
        for (genvar gi = 0; gi < N_SIZE; gi++) begin : g_unpack
            assign row_cols[gi] = row_in[(N_SIZE-1-gi)*EW +: EW];
        end
    endgenerate

    collector_index_gen #(
        .N_SIZE (N_SIZE),
        .IW     (IW)
    ) u_index_gen (
        .clk      (clk),
        .rst      (rst),
        .advance  (advance),
        .row      (out_row),
        .col      (out_col),
        .row_next (row_next),
        .col_next (col_next),
        .last     (out_last)
    );

    assign advance  = out_valid && out_ready;
    assign final_hs = (state_reg == DRAIN) && out_last && out_ready;
    // A row coinciding with the final handshake starts the next matrix instead of overrunning.
    assign wr_en    = valid_in && ((state_reg != DRAIN) || final_hs);
    assign wr_row   = (state_reg == COLLECT) ? row_cnt_reg : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            row_cnt_reg <= '0;
            overrun_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            row_cnt_reg <= row_cnt_next;
            overrun_reg <= overrun_reg | (valid_in && (state_reg == DRAIN) && !final_hs);
        end
    end

    always_comb begin
        state_next   = state_reg;
        row_cnt_next = row_cnt_reg;
        if (wr_en) begin
            row_cnt_next = (wr_row == LAST_IDX) ? '0 : wr_row + 1'b1;
        end
        case (state_reg)
            IDLE, COLLECT: begin
                if (wr_en) begin
                    state_next = (wr_row == LAST_IDX) ? DRAIN : COLLECT;
                end
            end
            DRAIN: begin
                if (final_hs) begin
                    if (wr_en) begin
                        state_next = (wr_row == LAST_IDX) ? DRAIN : COLLECT;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        out_valid = (state_reg == DRAIN);
        in_ready  = (state_reg != DRAIN);
        overrun   = overrun_reg;
        out_data  = out_data_reg;
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int j = 0; j < N_SIZE; j++) begin
                buf_mem[wr_row][j] <= row_cols[j];
            end
        end
    end

    // Prefetch the element at the next index; forward the incoming row when it is the one being read.
    always_comb begin
        out_data_next = buf_mem[row_next][col_next];
        if (wr_en && (wr_row == row_next)) begin
            out_data_next = row_cols[col_next];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_reg <= '0;
        end else begin
            out_data_reg <= out_data_next;
        end
    end

endmodule

// File: tb/tb_systolic_result_collector.sv
// Randomized self-checking bench for systolic_result_collector against a matrix-level reference model.
// Honors COLLECT_TRANSPOSE_EN when computing the expected drain order.
module tb_systolic_result_collector;

    localparam int DW = 16;
    localparam int N  = 5;
    localparam int EW = 2 * DW;
    localparam int NN = N * N;
    localparam int IW = 3;

    logic              clk;
    logic              rst;
    logic              valid_in;
    logic [N*EW-1:0]   row_in;
    logic              in_ready;
    logic              out_valid;
    logic              out_ready;
    logic [EW-1:0]     out_data;
    logic [IW-1:0]     out_row;
    logic [IW-1:0]     out_col;
    logic              out_last;
    logic              overrun;

    systolic_result_collector #(
        .DATAWIDTH (DW),
        .N_SIZE    (N)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .valid_in  (valid_in),
        .row_in    (row_in),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_row   (out_row),
        .out_col   (out_col),
        .out_last  (out_last),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;
    int ready_mode = 0;
    int cyc = 0;

    logic [EW-1:0] row_vals [N];
    logic [EW-1:0] got_q [$];

    // Reference model: the held matrix, whether it is being drained, and how far.
    logic [EW-1:0] m_mat [N][N];
    bit            m_drain = 1'b0;
    int            m_k     = 0;
    int            m_rows  = 0;
    bit            m_ovr   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int ord_row(input int k);
`ifdef COLLECT_TRANSPOSE_EN
        return k % N;
`else
        return k / N;
`endif
    endfunction

    function automatic int ord_col(input int k);
`ifdef COLLECT_TRANSPOSE_EN
        return k / N;
`else
        return k % N;
`endif
    endfunction

    always @(posedge clk) begin : model
        bit fin;
        cyc++;
        if (rst) begin
            m_drain = 1'b0;
            m_k     = 0;
            m_rows  = 0;
            m_ovr   = 1'b0;
        end else if (m_drain) begin
            fin = out_ready && (m_k == NN - 1);
            if (out_ready) m_k++;
            if (fin) begin
                m_drain = 1'b0;
                m_k     = 0;
                if (valid_in) begin
                    for (int j = 0; j < N; j++) m_mat[0][j] = row_in[(N-1-j)*EW +: EW];
                    m_rows = 1;
                end
            end else if (valid_in) begin
                m_ovr = 1'b1;
            end
        end else if (valid_in) begin
            for (int j = 0; j < N; j++) m_mat[m_rows][j] = row_in[(N-1-j)*EW +: EW];
            m_rows++;
            if (m_rows == N) begin
                m_drain = 1'b1;
                m_k     = 0;
                m_rows  = 0;
            end
        end
    end

    always @(negedge clk) begin : compare
        int r;
        int c;
        if (chk_en) begin
            chk("out_valid", {31'b0, out_valid}, {31'b0, m_drain});
            chk("in_ready", {31'b0, in_ready}, {31'b0, !m_drain});
            chk("overrun", {31'b0, overrun}, {31'b0, m_ovr});
            chk("out_last", {31'b0, out_last}, {31'b0, m_drain && (m_k == NN - 1)});
            if (m_drain) begin
                r = ord_row(m_k);
                c = ord_col(m_k);
                chk("out_data", out_data, m_mat[r][c]);
                chk("out_row", {29'b0, out_row}, r);
                chk("out_col", {29'b0, out_col}, c);
            end
            if (out_valid && out_ready) begin
                got_q.push_back(out_data);
                $display("xfer row=%0d col=%0d data=%0h last=%0d", out_row, out_col, out_data, out_last);
            end
        end
    end

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ((cyc % 3) == 0);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_row();
        for (int j = 0; j < N; j++) row_in[(N-1-j)*EW +: EW] = row_vals[j];
        valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
    endtask

    task automatic send_identity(input int gap);
        for (int r = 0; r < N; r++) begin
            for (int j = 0; j < N; j++) row_vals[j] = 32'(N * r + j + 1);
            if (r == N - 1) chk("valid_before_last_row", {31'b0, out_valid}, 32'd0);
            drive_row();
            if (r == N - 1) chk("first_valid_latency", {31'b0, out_valid}, 32'd1);
            repeat (gap) tick();
        end
    endtask

    task automatic send_random(input int maxgap);
        for (int r = 0; r < N; r++) begin
            for (int j = 0; j < N; j++) row_vals[j] = $urandom;
            drive_row();
            repeat ($urandom_range(0, maxgap)) tick();
        end
    endtask

    task automatic wait_done();
        int n = 0;
        while ((m_drain || m_rows != 0) && n < 2000) begin
            tick();
            n++;
        end
        chk("drain_timeout", {31'b0, n < 2000}, 32'd1);
    endtask

    task automatic wait_elem(input int k);
        int n = 0;
        while (!(m_drain && m_k == k) && n < 2000) begin
            tick();
            n++;
        end
        chk("wait_elem_timeout", {31'b0, n < 2000}, 32'd1);
    endtask

    task automatic check_identity(input int base, input string name);
        for (int k = 0; k < NN; k++) begin
            if (base + k < got_q.size())
                chk(name, got_q[base + k], 32'(ord_row(k) * N + ord_col(k) + 1));
        end
    endtask

    initial begin
        rst      = 1'b1;
        valid_in = 1'b0;
        row_in   = '0;
        tick();
        chk_en = 1'b1;
        tick();
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_out_rowcol", {26'b0, out_row, out_col}, 32'd0);
        chk("rst_overrun", {31'b0, overrun}, 32'd0);
        rst = 1'b0;
        tick();

        // Identity, continuous rows, ready held high
        got_q.delete();
        send_identity(0);
        wait_done();
        chk("identity_count", got_q.size(), NN);
        check_identity(0, "identity_val");

        // Gapped rows
        got_q.delete();
        send_identity(2);
        wait_done();
        chk("gapped_count", got_q.size(), NN);
        check_identity(0, "gapped_val");

        // Backpressure pattern 1,0,0
        ready_mode = 1;
        got_q.delete();
        send_identity(0);
        wait_done();
        chk("bp_count", got_q.size(), NN);
        check_identity(0, "bp_val");
        ready_mode = 0;
        tick();

        // Back-to-back: row 0 of matrix 2 lands on the final handshake of matrix 1
        got_q.delete();
        send_identity(0);
        wait_elem(NN - 1);
        send_random(0);
        wait_done();
        chk("b2b_count", got_q.size(), 2 * NN);
        check_identity(0, "b2b_m1_val");
        chk("b2b_overrun", {31'b0, overrun}, 32'd0);

        // Overrun during drain
        got_q.delete();
        send_identity(0);
        wait_elem(3);
        for (int j = 0; j < N; j++) row_vals[j] = 32'hdead0000 + 32'(j);
        drive_row();
        chk("overrun_set", {31'b0, overrun}, 32'd1);
        wait_done();
        check_identity(0, "overrun_val");
        got_q.delete();
        send_identity(1);
        wait_done();
        check_identity(0, "post_overrun_val");
        chk("overrun_sticky", {31'b0, overrun}, 32'd1);

        // Reset in the middle of a drain
        send_identity(0);
        wait_elem(10);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("midrst_rowcol", {26'b0, out_row, out_col}, 32'd0);
        chk("midrst_overrun", {31'b0, overrun}, 32'd0);
        got_q.delete();
        send_identity(0);
        wait_done();
        chk("midrst_count", got_q.size(), NN);
        check_identity(0, "midrst_val");

        // Randomized matrices, random ready, occasional stray rows during drain
        ready_mode = 2;
        for (int m = 0; m < 8; m++) begin
            send_random(3);
            if ($urandom_range(0, 2) == 0) begin
                wait_elem(int'($urandom_range(0, NN - 2)));
                for (int j = 0; j < N; j++) row_vals[j] = $urandom;
                drive_row();
            end
            wait_done();
            repeat ($urandom_range(0, 3)) tick();
        end
        ready_mode = 0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
